// File: rtl/billiard_pkg.sv
// billiard_pkg: shared collision event types for the billiard datapath.
package billiard_pkg;
  localparam int NUM_BALLS = 2;
  typedef enum logic [1:0] {EV_NONE, EV_BB, EV_HOLE, EV_WALL} ev_type_t;
  typedef enum logic {COLLECT, DRAIN} state_t;
  typedef struct packed {
    ev_type_t    etype;
    logic [3:0]  id_a;
    logic [3:0]  id_b;
    logic [1:0]  wall;
  } collision_ev_t;
  localparam collision_ev_t EV_EMPTY = '0;
  function automatic logic [3:0] low_idx(input logic [15:0] v);
    low_idx = '0;
    for (int i = 15; i >= 0; i--) if (v[i]) low_idx = 4'(i);
  endfunction
endpackage

// File: rtl/collision_dispatch_if.sv
// collision_dispatch_if: valid/ready event stream from dispatcher to physics.
interface collision_dispatch_if;
  logic       ev_valid;
  logic       ev_ready;
  logic [1:0] ev_type;
  logic [3:0] ev_id_a;
  logic [3:0] ev_id_b;
  logic [1:0] ev_wall;
  modport master(output ev_valid, ev_type, ev_id_a, ev_id_b, ev_wall, input ev_ready);
  modport slave(input ev_valid, ev_type, ev_id_a, ev_id_b, ev_wall, output ev_ready);
endinterface

// File: rtl/collision_event_fifo.sv
// collision_event_fifo: DEPTH-entry synchronous FIFO of collision events.
module collision_event_fifo
  import billiard_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  collision_ev_t              din,
  output collision_ev_t              head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  collision_ev_t mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic push_ok, pop_ok;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign push_ok = push && !full;
  assign pop_ok = pop && !empty;
  assign head = mem[rp];
  always_ff @(posedge clk) if (push_ok) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(push_ok);
      rp <= rp + AW'(pop_ok);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end
endmodule

// File: rtl/collision_dispatch.sv
// collision_dispatch: stages per-frame collision pulses, queues them and replays them after startOfFrame.
module collision_dispatch
  import billiard_pkg::*;
#(
  parameter int NUM_BALLS = 2,
  parameter int DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 startOfFrame,
  input  logic [NUM_BALLS:0]   balls_collide,
  input  logic [1:0][3:0]      Balls_col_ID,
  input  logic [NUM_BALLS:0]   ballhole_collide,
  input  logic [NUM_BALLS:0]   ballwall_collide,
  input  logic [1:0]           collided_wall,
  collision_dispatch_if.master ev,
  output logic [NUM_BALLS:0]   pocketed_mask,
  output logic [7:0]           drop_count,
  output logic                 frame_overrun
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int NB = NUM_BALLS + 1;
  state_t state, state_n;
  collision_ev_t hole_s, bb_s, wall_s, hole_n, bb_n, wall_n, push_ev, head;
  logic [CW-1:0] count, remaining, rem_n;
  logic full, empty, push, pop, valid, any_occ;
  logic hole_occ, bb_occ, wall_occ, dr_hole, dr_bb, dr_wall, cap_hole, cap_bb, cap_wall;
  logic [2:0] n_drop;
  logic [8:0] drop_sum;
  assign hole_occ = hole_s.etype != EV_NONE;
  assign bb_occ = bb_s.etype != EV_NONE;
  assign wall_occ = wall_s.etype != EV_NONE;
  assign any_occ = hole_occ || bb_occ || wall_occ;
  assign dr_hole = hole_occ;
  assign dr_bb = bb_occ && !hole_occ;
  assign dr_wall = wall_occ && !hole_occ && !bb_occ;
  assign push_ev = hole_occ ? hole_s : (bb_occ ? bb_s : wall_s);
  assign push = any_occ && !full;
  assign cap_hole = |ballhole_collide;
  assign cap_bb = |balls_collide;
  assign cap_wall = |ballwall_collide;
  assign hole_n = '{EV_HOLE, low_idx(16'(ballhole_collide)), 4'd0, 2'd0};
  assign bb_n = '{EV_BB, Balls_col_ID[0], Balls_col_ID[1], 2'd0};
  assign wall_n = '{EV_WALL, low_idx(16'(ballwall_collide)), 4'd0, collided_wall};
  // a slot being drained this cycle may take a new capture without losing either event
  assign n_drop = 3'(cap_hole && hole_occ && !dr_hole) + 3'(cap_bb && bb_occ && !dr_bb)
                + 3'(cap_wall && wall_occ && !dr_wall) + 3'(any_occ && full);
  assign drop_sum = {1'b0, drop_count} + 9'(n_drop);
  assign pop = valid && ev.ev_ready && !empty;
  collision_event_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .din(push_ev),
    .head(head), .count(count), .full(full), .empty(empty)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      hole_s <= EV_EMPTY;
      bb_s <= EV_EMPTY;
      wall_s <= EV_EMPTY;
    end else begin
      hole_s <= (cap_hole && (!hole_occ || dr_hole)) ? hole_n : (dr_hole ? EV_EMPTY : hole_s);
      bb_s <= (cap_bb && (!bb_occ || dr_bb)) ? bb_n : (dr_bb ? EV_EMPTY : bb_s);
      wall_s <= (cap_wall && (!wall_occ || dr_wall)) ? wall_n : (dr_wall ? EV_EMPTY : wall_s);
    end
  end
  always_ff @(posedge clk) state <= reset ? COLLECT : state_n;
  // count is the pre-edge occupancy, so same-edge pushes wait for the next frame
  always_comb begin
    rem_n = (startOfFrame ? count : remaining) - CW'(pop);
    state_n = (rem_n != '0) ? DRAIN : COLLECT;
  end
  always_comb begin
    valid = state == DRAIN;
    ev.ev_valid = valid;
    ev.ev_type = valid ? head.etype : EV_NONE;
    ev.ev_id_a = valid ? head.id_a : 4'd0;
    ev.ev_id_b = valid ? head.id_b : 4'd0;
    ev.ev_wall = valid ? head.wall : 2'd0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      remaining <= '0;
      drop_count <= '0;
      frame_overrun <= 1'b0;
      pocketed_mask <= '0;
    end else begin
      remaining <= rem_n;
      drop_count <= drop_sum[8] ? 8'hff : drop_sum[7:0];
      frame_overrun <= frame_overrun | (startOfFrame && state == DRAIN);
      if (pop && head.etype == EV_HOLE) pocketed_mask <= pocketed_mask | (NB'(1) << head.id_a);
    end
  end
endmodule

// File: doc/collision_dispatch.md
# collision_dispatch

Consumer end of the per-frame collision pulses produced by the hit detector: captures ball-ball, ball-hole and ball-wall events as they occur during scan-out, queues them, and replays them to the physics/speed-update logic one at a time over a valid/ready handshake starting at the next `startOfFrame`. It also keeps the authoritative pocketed-ball mask, so game logic sees pockets only when physics has consumed them.

## Interface
Parameters:
- `NUM_BALLS`, 2: highest ball index; vectors are `[NUM_BALLS:0]`.
- `DEPTH`, 8: event FIFO entries, power of two, ≥2.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset; one clock, synchronous active-high reset.
- `startOfFrame` in 1: one-cycle pulse per frame.
- `balls_collide` in NUM_BALLS+1: ball-ball pulse, two bits set.
- `Balls_col_ID` in [1:0][3:0]: IDs for `balls_collide`, valid in the same cycle.
- `ballhole_collide` in NUM_BALLS+1: ball-hole pulse.
- `ballwall_collide` in NUM_BALLS+1: ball-wall pulse.
- `collided_wall` in 2: wall code for `ballwall_collide`.
- `ev_valid` out 1: event presented.
- `ev_ready` in 1: consumer accepts.
- `ev_type` out 2: 0 none, 1 ball-ball, 2 ball-hole, 3 ball-wall.
- `ev_id_a`, `ev_id_b` out 4 each: ball IDs (`ev_id_b` 0 unless ball-ball).
- `ev_wall` out 2: wall code (0 unless ball-wall).
- `pocketed_mask` out NUM_BALLS+1: balls whose hole event was delivered.
- `drop_count` out 8: saturating count of lost events.
- `frame_overrun` out 1: sticky; a drain was still pending at `startOfFrame`.

## Operation
- Capture: a nonzero pulse vector loads its staging slot (BB, HOLE, WALL) with `{type, id_a, id_b, wall}`. HOLE/WALL `id_a` = lowest set bit index. BB `id_a`/`id_b` = `Balls_col_ID[0]`/`[1]`. A pulse for an already-occupied slot is dropped and increments `drop_count`.
- Arbiter moves one occupied slot per cycle into the FIFO, priority HOLE > BB > WALL. FIFO full: the slot is cleared, the event dropped, and `drop_count` increments. Slot capture and arbiter drain of the same slot in the same cycle: the new event is kept in the slot.
- FSM COLLECT/DRAIN. On `startOfFrame`, `remaining` ← FIFO occupancy at that edge, excluding events written on the same edge and events still staged. State → DRAIN if `remaining` ≠ 0, else stays COLLECT.
- DRAIN: `ev_valid` = 1 and `ev_*` = FIFO head. On `ev_valid && ev_ready`: pop and decrement `remaining`. Reaching 0 → COLLECT. Capture and push continue during DRAIN.
- `startOfFrame` during DRAIN: set `frame_overrun`, reload `remaining` with full occupancy, stay DRAIN.
- Pop of type 2 sets `pocketed_mask[ev_id_a]`; the mask is never cleared except by reset.
- `ev_*` are 0 whenever `ev_valid` = 0.

## Timing
- Reset: all outputs 0, state COLLECT, FIFO and slots empty, `remaining` 0.
- Pulse at edge t → staged after t → in FIFO after t+1 at the earliest. Lower-priority slots wait one extra cycle per higher occupied slot.
- `startOfFrame` sampled at edge s → `ev_valid` high in cycle s+1 if any events were counted.
- Handshake: `ev_*` stable while `ev_valid && !ev_ready`. Sustained ready gives one event per cycle.
- Reset mid-DRAIN discards all queued events and the pocketed mask.
- `drop_count` saturates at 255.

## Structure
- Shared `billiard_pkg`: `NUM_BALLS`, `ev_type_t` enum {EV_NONE, EV_BB, EV_HOLE, EV_WALL}, packed `collision_ev_t` struct {type, id_a, id_b, wall}.
- Sub-module `collision_event_fifo`: DEPTH-entry synchronous FIFO of `collision_ev_t` with `push`, `pop`, `count`, `full`, `empty`, and head output. Staging, arbiter, FSM and pocket mask live in the top.

## Test plan
- `ballhole_collide`=3'b010, then `startOfFrame` 5 cycles later, `ev_ready`=1 → one cycle of `ev_valid`, type 2, `id_a`=1; `pocketed_mask`=3'b010 after the pop.
- Same-cycle BB (IDs 0,2), HOLE 3'b001, WALL 3'b100 wall 2'b01 → delivery order after SOF is HOLE(0), BB(0,2), WALL(2, wall 1).
- Push 10 events (DEPTH=8, `ev_ready`=0) → `drop_count`=2. After SOF, 8 events delivered in FIFO order.
- Event staged on the same edge as `startOfFrame` → not delivered this drain; `ev_valid` low after the others. Delivered after the next SOF.
- `ev_ready` held 0 across the next `startOfFrame` → `frame_overrun`=1, head unchanged and stable, `remaining` reloaded.
- `reset` asserted in DRAIN with 3 queued → next cycle `ev_valid`=0, `pocketed_mask`=0, `drop_count`=0, state COLLECT.
